wb_gpio_irq: RTL



---
 rtl/wb_gpio_irq.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/wb_gpio_irq.sv
// Wishbone GPIO peripheral: direction control, atomic set/clear, synchronised
// inputs and edge-triggered maskable interrupt with a single registered irq line.
`timescale 1ns/1ps
module wb_gpio_irq #(
    parameter int          GPIO_WIDTH  = 32,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] OUT_RESET   = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [31:0]           wb_adr_i,
    input  logic [3:0]            wb_sel_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic [GPIO_WIDTH-1:0] gpio_oe_o,
    output logic                  irq_o
);

    // Bits at or above GPIO_WIDTH are never stored, so every register is masked.
    localparam logic [31:0] WMASK = 32'hFFFF_FFFF >> (32 - GPIO_WIDTH);

    localparam logic [2:0] OFF_OUT   = 3'd0;
    localparam logic [2:0] OFF_IN    = 3'd1;
    localparam logic [2:0] OFF_DIR   = 3'd2;
    localparam logic [2:0] OFF_IMASK = 3'd3;
    localparam logic [2:0] OFF_IEDGE = 3'd4;
    localparam logic [2:0] OFF_ISTAT = 3'd5;
    localparam logic [2:0] OFF_SET   = 3'd6;
    localparam logic [2:0] OFF_CLR   = 3'd7;

    logic [31:0] out_r;
    logic [31:0] dir_r;
    logic [31:0] imask_r;
    logic [31:0] iedge_r;
    logic [31:0] istat_r;
    logic [31:0] dat_r;
    logic        ack_r;
    logic        err_r;
    logic        irq_r;

    logic [SYNC_STAGES-1:0][GPIO_WIDTH-1:0] sync_r;
    logic [GPIO_WIDTH-1:0]                  prev_r;

    logic        access_s;
    logic        wr_s;
    logic [2:0]  off_s;
    logic [31:0] lane_s;
    logic [31:0] wdat_s;
    logic [31:0] sync_ext_s;
    logic [31:0] prev_ext_s;
    logic [31:0] hit_s;
    logic [31:0] w1c_s;
    logic [31:0] rdata_s;
    logic        unused_s;

    assign access_s = wb_cyc_i & wb_stb_i & ~ack_r & ~err_r;
    assign wr_s     = access_s & wb_we_i;
    assign off_s    = wb_adr_i[4:2];
    assign lane_s   = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign wdat_s   = wb_dat_i & lane_s & WMASK;
    assign unused_s = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

    // Zero-extend the synchroniser taps and derive per-bit edge hits.
    always_comb begin
        sync_ext_s = 32'h0000_0000;
        prev_ext_s = 32'h0000_0000;
        sync_ext_s[GPIO_WIDTH-1:0] = sync_r[SYNC_STAGES-1];
        prev_ext_s[GPIO_WIDTH-1:0] = prev_r;
        hit_s = ((iedge_r & sync_ext_s & ~prev_ext_s) |
                 (~iedge_r & ~sync_ext_s & prev_ext_s)) & WMASK;
    end

    // Write-one-to-clear mask for ISTAT, active only on a committing write.
    always_comb begin
        if (wr_s && (off_s == OFF_ISTAT)) begin
            w1c_s = wdat_s;
        end else begin
            w1c_s = 32'h0000_0000;
        end
    end

    // Read multiplexer; write-only offsets return zero.
    always_comb begin
        case (off_s)
            OFF_OUT:   rdata_s = out_r;
            OFF_IN:    rdata_s = sync_ext_s;
            OFF_DIR:   rdata_s = dir_r;
            OFF_IMASK: rdata_s = imask_r;
            OFF_IEDGE: rdata_s = iedge_r;
            OFF_ISTAT: rdata_s = istat_r;
            OFF_SET:   rdata_s = 32'h0000_0000;
            OFF_CLR:   rdata_s = 32'h0000_0000;
            default:   rdata_s = 32'h0000_0000;
        endcase
    end

    // Input synchroniser chain plus the one-cycle-older copy for edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_r <= '0;
            prev_r <= '0;
        end else begin
            sync_r[0] <= gpio_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    // Bus handshake: one-cycle ack, data valid only in the ack cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
            dat_r <= 32'h0000_0000;
        end else begin
            ack_r <= access_s;
            err_r <= 1'b0;
            dat_r <= access_s ? rdata_s : 32'h0000_0000;
        end
    end

    // Control registers commit on the edge that raises ack.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_r   <= OUT_RESET & WMASK;
            dir_r   <= 32'h0000_0000;
            imask_r <= 32'h0000_0000;
            iedge_r <= 32'h0000_0000;
        end else if (wr_s) begin
            case (off_s)
                OFF_OUT:   out_r   <= (out_r & ~(lane_s & WMASK)) | wdat_s;
                OFF_DIR:   dir_r   <= (dir_r & ~(lane_s & WMASK)) | wdat_s;
                OFF_IMASK: imask_r <= (imask_r & ~(lane_s & WMASK)) | wdat_s;
                OFF_IEDGE: iedge_r <= (iedge_r & ~(lane_s & WMASK)) | wdat_s;
                OFF_SET:   out_r   <= out_r | wdat_s;
                OFF_CLR:   out_r   <= out_r & ~wdat_s;
                default:   out_r   <= out_r;
            endcase
        end else begin
            out_r <= out_r;
        end
    end

    // Interrupt status: a hit in the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            istat_r <= 32'h0000_0000;
            irq_r   <= 1'b0;
        end else begin
            istat_r <= (istat_r & ~w1c_s) | hit_s;
            irq_r   <= |(istat_r & imask_r);
        end
    end

    assign wb_ack_o  = ack_r;
    assign wb_err_o  = err_r;
    assign wb_dat_o  = dat_r;
    assign gpio_o    = out_r[GPIO_WIDTH-1:0];
    assign gpio_oe_o = dir_r[GPIO_WIDTH-1:0];
    assign irq_o     = irq_r;

endmodule
